dff_seu_monitor: RTL and testbench



---
 rtl/dff_seu_monitor.sv | 150 +++++++++++++++
 tb/tb_dff_seu_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_seu_monitor.sv
// dff_seu_monitor: per-channel DFF-chain upset counters with a framed serial
// snapshot that the Pi reads out through a sampled shift clock.
`timescale 1ns/1ps
module dff_seu_monitor #(
  parameter int unsigned N_CH  = 19,
  parameter int unsigned CNT_W = 16,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic            CLK_50M,
  input  logic            RST_N,
  input  logic [N_CH-1:0] ch_in,
  input  logic [1:0]      mode,
  input  logic            save_data_pi,
  input  logic            data_clk_pi,
  output logic            data_out_pi,
  output logic            frame_ready
);

  localparam int unsigned FRAME_W = 8 + N_CH * CNT_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [N_CH-1:0] odd_mask();
    logic [N_CH-1:0] m;
    for (int unsigned i = 0; i < N_CH; i++) m[i] = i[0];
    return m;
  endfunction

  localparam logic [N_CH-1:0] ODD = odd_mask();

  logic [N_CH-1:0]    ch_meta_q, ch_meta_d, ch_sync_q, ch_sync_d;
  logic [1:0]         mode_meta_q, mode_meta_d, mode_sync_q, mode_sync_d;
  logic               save_meta_q, save_meta_d, save_sync_q, save_sync_d;
  logic               dclk_meta_q, dclk_meta_d, dclk_sync_q, dclk_sync_d;
  logic [1:0]         mode_q, mode_d;
  logic               save_q, save_d, dclk_q, dclk_d;
  logic [N_CH-1:0]    prev_q, prev_d, mis_q, mis_d, mis_prev_q, mis_prev_d;
  logic [CNT_W-1:0]   cnt_q [N_CH];
  logic [CNT_W-1:0]   cnt_d [N_CH];
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic               ready_q, ready_d;

  logic               mode_chg, save_rise, shift_rise;
  logic [N_CH-1:0]    mis_now, evt;
  logic [FRAME_W-1:0] frame;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      ch_meta_q   <= '0;
      ch_sync_q   <= '0;
      mode_meta_q <= '0;
      mode_sync_q <= '0;
      save_meta_q <= 1'b0;
      save_sync_q <= 1'b0;
      dclk_meta_q <= 1'b0;
      dclk_sync_q <= 1'b0;
      mode_q      <= '0;
      save_q      <= 1'b0;
      dclk_q      <= 1'b0;
      prev_q      <= '0;
      mis_q       <= '0;
      mis_prev_q  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      sr_q        <= '0;
      bits_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      ch_meta_q   <= ch_meta_d;
      ch_sync_q   <= ch_sync_d;
      mode_meta_q <= mode_meta_d;
      mode_sync_q <= mode_sync_d;
      save_meta_q <= save_meta_d;
      save_sync_q <= save_sync_d;
      dclk_meta_q <= dclk_meta_d;
      dclk_sync_q <= dclk_sync_d;
      mode_q      <= mode_d;
      save_q      <= save_d;
      dclk_q      <= dclk_d;
      prev_q      <= prev_d;
      mis_q       <= mis_d;
      mis_prev_q  <= mis_prev_d;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      sr_q        <= sr_d;
      bits_q      <= bits_d;
      ready_q     <= ready_d;
    end
  end

  // Synchronisers and edge-detect history
  always_comb begin
    ch_meta_d   = ch_in;
    ch_sync_d   = ch_meta_q;
    mode_meta_d = mode;
    mode_sync_d = mode_meta_q;
    save_meta_d = save_data_pi;
    save_sync_d = save_meta_q;
    dclk_meta_d = data_clk_pi;
    dclk_sync_d = dclk_meta_q;
    mode_d      = mode_sync_q;
    save_d      = save_sync_q;
    dclk_d      = dclk_sync_q;
    mode_chg    = (mode_sync_q != mode_q);
    save_rise   = save_sync_q & ~save_q;
    shift_rise  = dclk_sync_q & ~dclk_q & ready_q;
  end

  // Mismatch pipeline and per-channel saturating event counters
  always_comb begin
    case (mode_q)
      2'd0:    mis_now = ch_sync_q;
      2'd1:    mis_now = ~ch_sync_q;
      2'd2:    mis_now = ch_sync_q ^ ODD;
      default: mis_now = ch_sync_q ^ prev_q;
    endcase
    evt        = (mode_q == 2'd3) ? mis_q : (mis_q & ~mis_prev_q);
    prev_d     = mode_chg ? '0 : ch_sync_q;
    mis_d      = mode_chg ? '0 : mis_now;
    mis_prev_d = mode_chg ? '0 : mis_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = (save_rise || mode_chg) ? '0 : cnt_q[i];
      if (!mode_chg && evt[i] && (cnt_d[i] != CNT_MAX))
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
    end
  end

  // Frame snapshot and Pi-driven shift-out; a save always restarts the frame
  always_comb begin
    frame = '0;
    frame[FRAME_W-1 -: 8] = HDR;
    for (int unsigned i = 0; i < N_CH; i++)
      frame[FRAME_W - 9 - i * CNT_W -: CNT_W] = cnt_q[i];
    sr_d    = sr_q;
    bits_d  = bits_q;
    ready_d = ready_q;
    if (save_rise) begin
      sr_d    = frame;
      bits_d  = BIT_W'(FRAME_W);
      ready_d = 1'b1;
    end else if (shift_rise) begin
      sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
      bits_d  = bits_q - BIT_W'(1);
      ready_d = (bits_q != BIT_W'(1));
    end
  end

  assign data_out_pi = sr_q[FRAME_W-1];
  assign frame_ready = ready_q;

endmodule

// File: tb/tb_dff_seu_monitor.sv
// Bench for dff_seu_monitor: expected frame fields are queued as stimulus is
// issued; a monitor assembles bits on each Pi shift-clock rise and compares.
`timescale 1ns/1ps
module tb_dff_seu_monitor;

  localparam int unsigned NCH = 19;
  localparam logic [NCH-1:0] CHK = 19'h2AAAA;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] ch_a, ch_b;
  logic [1:0]     mode_a, mode_b;
  logic           save_a, save_b, dclk_a, dclk_b;
  logic           dout_a, dout_b, rdy_a, rdy_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    int unsigned w;
    logic [31:0] v;
  } fld_t;

  fld_t        exp_q[$];
  int unsigned ecnt [NCH];

  always #10 clk = ~clk;

  dff_seu_monitor #(.N_CH(NCH), .CNT_W(16), .HDR(8'hA5)) u_dut_a (
    .CLK_50M(clk), .RST_N(rst_n), .ch_in(ch_a), .mode(mode_a),
    .save_data_pi(save_a), .data_clk_pi(dclk_a),
    .data_out_pi(dout_a), .frame_ready(rdy_a)
  );

  dff_seu_monitor #(.N_CH(NCH), .CNT_W(4), .HDR(8'hA5)) u_dut_b (
    .CLK_50M(clk), .RST_N(rst_n), .ch_in(ch_b), .mode(mode_b),
    .save_data_pi(save_b), .data_clk_pi(dclk_b),
    .data_out_pi(dout_b), .frame_ready(rdy_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // Field monitor: one bit per shift-clock rise, MSB first
  initial begin : monitor
    logic [31:0] acc;
    int unsigned nacc;
    logic        b;
    fld_t        f;
    acc  = '0;
    nacc = 0;
    forever begin
      @(posedge dclk_a or posedge dclk_b);
      b = dclk_b ? dout_b : dout_a;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bit: got bit %0d, required none queued", b);
      end else begin
        acc = {acc[30:0], b};
        nacc++;
        if (nacc == exp_q[0].w) begin
          f = exp_q.pop_front();
          check(f.name, acc, f.v);
          acc  = '0;
          nacc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string name, input int unsigned w, input logic [31:0] v);
    fld_t f;
    f.name = name;
    f.w    = w;
    f.v    = v;
    exp_q.push_back(f);
  endtask

  task automatic push_frame(input int unsigned w);
    push("hdr", 8, 32'hA5);
    for (int i = 0; i < NCH; i++) begin
      push($sformatf("ch%0d", i), w, ecnt[i]);
      ecnt[i] = 0;
    end
  endtask

  task automatic do_save(input bit bi);
    if (bi) save_b = 1'b1; else save_a = 1'b1;
    cyc(6);
    check(bi ? "b_ready_on_load" : "a_ready_on_load", 32'(bi ? rdy_b : rdy_a), 32'd1);
    check(bi ? "b_first_bit" : "a_first_bit", 32'(bi ? dout_b : dout_a), 32'd1);
    if (bi) save_b = 1'b0; else save_a = 1'b0;
    cyc(6);
  endtask

  task automatic shift_bit(input bit bi);
    cyc(5);
    if (bi) dclk_b = 1'b1; else dclk_a = 1'b1;
    cyc(5);
    if (bi) dclk_b = 1'b0; else dclk_a = 1'b0;
  endtask

  task automatic read_bits(input bit bi, input int n);
    for (int k = 0; k < n; k++) shift_bit(bi);
  endtask

  task automatic read_frame(input bit bi, input int n);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1)
        check("ready_before_last", 32'(bi ? rdy_b : rdy_a), 32'd1);
      shift_bit(bi);
    end
    cyc(5);
    check("ready_after_last", 32'(bi ? rdy_b : rdy_a), 32'd0);
    check("dout_after_last", 32'(bi ? dout_b : dout_a), 32'd0);
  endtask

  task automatic pulse(input bit bi, input int ch, input int hi, input int lo);
    if (bi) ch_b[ch] = 1'b1; else ch_a[ch] = 1'b1;
    cyc(hi);
    if (bi) ch_b[ch] = 1'b0; else ch_a[ch] = 1'b0;
    cyc(lo);
  endtask

  localparam int FA = 8 + NCH * 16;
  localparam int FB = 8 + NCH * 4;

  initial begin : stim
    rst_n  = 1'b0;
    ch_a   = '0;
    ch_b   = '0;
    mode_a = 2'd0;
    mode_b = 2'd0;
    save_a = 1'b0;
    save_b = 1'b0;
    dclk_a = 1'b0;
    dclk_b = 1'b0;
    for (int i = 0; i < NCH; i++) ecnt[i] = 0;
    cyc(3);
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_ready_a", 32'(rdy_a), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);
    check("rst_ready_b", 32'(rdy_b), 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // Idle channels: header then all-zero counters
    push_frame(16);
    do_save(0);
    read_frame(0, FA);

    // Mode 0: three pulses on ch3, ch5 stuck high at save time
    repeat (3) pulse(0, 3, 10, 10);
    ch_a[5] = 1'b1;
    cyc(1000);
    ecnt[3] = 3;
    ecnt[5] = 1;
    push_frame(16);
    do_save(0);
    ch_a[5] = 1'b0;
    read_frame(0, FA);

    // Mode 3: every transition counts; a second save sees a fresh window
    mode_a = 2'd3;
    cyc(10);
    repeat (100) begin
      ch_a[0] = ~ch_a[0];
      cyc(4);
    end
    cyc(10);
    ecnt[0] = 100;
    push_frame(16);
    do_save(0);
    read_frame(0, FA);
    push_frame(16);
    do_save(0);
    read_frame(0, FA);

    // Mode 2 checkerboard, one flip on ch2
    mode_a = 2'd2;
    ch_a   = CHK;
    cyc(10);
    ch_a[2] = 1'b1;
    cyc(10);
    ecnt[2] = 1;
    push_frame(16);
    do_save(0);
    read_frame(0, FA);

    // Event on ch4, then mode change to 1 discards it
    ch_a[4] = 1'b1;
    cyc(10);
    mode_a = 2'd1;
    ch_a   = '1;
    cyc(10);
    push_frame(16);
    do_save(0);
    read_frame(0, FA);

    // Abort after 100 bits: the reload must restart at the header
    mode_a = 2'd0;
    ch_a   = '0;
    cyc(10);
    repeat (2) pulse(0, 0, 4, 6);
    cyc(10);
    push("hdr", 8, 32'hA5);
    push("ch0_part", 16, 32'd2);
    push("zeros_a", 32, 32'd0);
    push("zeros_b", 32, 32'd0);
    push("zeros_c", 12, 32'd0);
    do_save(0);
    read_bits(0, 100);
    pulse(0, 1, 4, 10);
    ecnt[1] = 1;
    push_frame(16);
    do_save(0);
    read_frame(0, FA);

    // Reset mid-readout discards the frame and the pending counts
    pulse(0, 2, 4, 10);
    push("hdr", 8, 32'hA5);
    push("ch0_top12", 12, 32'd0);
    do_save(0);
    read_bits(0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dout", 32'(dout_a), 32'd0);
    check("rst_mid_ready", 32'(rdy_a), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("post_rst_ready", 32'(rdy_a), 32'd0);
    push_frame(16);
    do_save(0);
    read_frame(0, FA);

    // CNT_W=4 instance: 20 events saturate at 15
    repeat (20) pulse(1, 1, 4, 4);
    cyc(10);
    ecnt[1] = 15;
    push_frame(4);
    do_save(1);
    read_frame(1, FB);

    cyc(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
